// File: rtl/fetch_pc_predictor.sv
// Fetch-stage PC register with a direct-mapped BTB and 2-bit bimodal counters.
// Predicts the next fetch address from pc_q and trains from resolved EX outcomes.
module fetch_pc_predictor #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BTB_IDX_W = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pc_stall,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_inst,
    output logic [31:0] if_pc,
    output logic [31:0] if_next_pc,
    output logic [31:0] if_inst,
    output logic        if_predicted_bit,
    input  logic        ex_update,
    input  logic [31:0] ex_pc,
    input  logic        ex_taken,
    input  logic [31:0] ex_target,
    input  logic        ex_mispredict,
    input  logic [31:0] ex_redirect_pc
);
    localparam int ENTRIES = 1 << BTB_IDX_W;
    localparam int TAG_W   = 32 - BTB_IDX_W - 2;

    logic [31:0]      pc_q, pc_d;
    logic             valid_q  [ENTRIES];
    logic [TAG_W-1:0] tag_q    [ENTRIES];
    logic [31:0]      target_q [ENTRIES];
    logic [1:0]       ctr_q    [ENTRIES];

    function automatic logic [1:0] sat_inc(input logic [1:0] c);
        return (c == 2'b11) ? c : c + 2'b01;
    endfunction

    function automatic logic [1:0] sat_dec(input logic [1:0] c);
        return (c == 2'b00) ? c : c - 2'b01;
    endfunction

    logic [BTB_IDX_W-1:0] if_idx, ex_idx;
    logic [TAG_W-1:0]     if_tag, ex_tag;
    logic                 if_hit, ex_hit;
    logic                 unused_ex_pc_lsb;

    assign if_idx = pc_q[BTB_IDX_W+1:2];
    assign if_tag = pc_q[31:BTB_IDX_W+2];
    assign ex_idx = ex_pc[BTB_IDX_W+1:2];
    assign ex_tag = ex_pc[31:BTB_IDX_W+2];
    assign unused_ex_pc_lsb = ^ex_pc[1:0];

    // Lookup reads the registered tables, so a same-cycle update is seen next cycle.
    assign if_hit = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    assign ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);

    assign if_pc            = pc_q;
    assign imem_addr        = pc_q;
    assign if_inst          = imem_inst;
    assign if_predicted_bit = if_hit && ctr_q[if_idx][1];
    assign if_next_pc       = if_predicted_bit ? target_q[if_idx] : pc_q + 32'd4;

    always_comb begin
        pc_d = if_next_pc;
        if (ex_mispredict) begin
            pc_d = ex_redirect_pc;
        end else if (pc_stall) begin
            pc_d = pc_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    // Training ignores stall/redirect: EX outcomes are architectural facts.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= 2'b01;
            end
        end else if (ex_update) begin
            if (ex_taken) begin
                target_q[ex_idx] <= ex_target;
                if (ex_hit) begin
                    ctr_q[ex_idx] <= sat_inc(ctr_q[ex_idx]);
                end else begin
                    valid_q[ex_idx] <= 1'b1;
                    tag_q[ex_idx]   <= ex_tag;
                    ctr_q[ex_idx]   <= 2'b10;
                end
            end else if (ex_hit) begin
                ctr_q[ex_idx] <= sat_dec(ctr_q[ex_idx]);
            end
        end
    end
endmodule
